// File: rtl/reflet_mem_responder_pkg.sv
// Shared constants and types for the Reflet memory responder: MMIO offsets and register bit indices.
package reflet_mem_responder_pkg;

  localparam int unsigned MMIO_OFF_W = 3;
  localparam int unsigned GPIO_W     = 8;
  localparam int unsigned CTRL_W     = 2;
  localparam int unsigned STATUS_W   = 2;

  localparam int unsigned CTRL_TIMER_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN    = 1;
  localparam int unsigned STATUS_EXPIRED = 0;
  localparam int unsigned STATUS_BUS_ERR = 1;

  typedef enum logic [MMIO_OFF_W-1:0] {
    MMIO_GPIO_OUT = 3'd0,
    MMIO_GPIO_IN  = 3'd1,
    MMIO_CYCLES   = 3'd2,
    MMIO_RELOAD   = 3'd3,
    MMIO_COUNT    = 3'd4,
    MMIO_CTRL     = 3'd5,
    MMIO_STATUS   = 3'd6,
    MMIO_SCRATCH  = 3'd7
  } mmio_off_e;

  // Address decode result; exactly one field is set for any address.
  typedef struct packed {
    logic mmio;
    logic ram;
    logic unmapped;
  } decode_t;

endpackage

// File: rtl/reflet_mem_responder_timer.sv
// Reload timer: COUNT counts down to zero, reloads from RELOAD and pulses expire_c.
module reflet_mmio_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         reload_we,
  input  logic [W-1:0] reload_wdata,
  output logic [W-1:0] reload,
  output logic [W-1:0] count,
  output logic         expire_c
);

  logic [W-1:0] reload_q, reload_d;
  logic [W-1:0] count_q, count_d;

  // Next-state: a RELOAD write takes priority over the count step of the same cycle.
  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    expire_c = 1'b0;
    if (reload_we) begin
      reload_d = reload_wdata;
      count_d  = reload_wdata;
    end else if (en) begin
      if (count_q == '0) begin
        count_d  = reload_q;
        expire_c = 1'b1;
      end else begin
        count_d = count_q - W'(1);
      end
    end
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      reload_q <= '0;
      count_q  <= '0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
    end
  end

  assign reload = reload_q;
  assign count  = count_q;

endmodule

// File: rtl/reflet_mem_responder.sv
// Reflet CPU RAM-bus responder: word RAM plus eight MMIO registers, 1-cycle read latency.
module reflet_mem_responder
  import reflet_mem_responder_pkg::*;
#(
  parameter int unsigned wordsize  = 16,
  parameter int unsigned ram_words = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_wdata,
  input  logic                cpu_we,
  output logic [wordsize-1:0] cpu_rdata,
  input  logic [GPIO_W-1:0]   gpio_in,
  output logic [GPIO_W-1:0]   gpio_out,
  output logic                timer_irq,
  output logic                bus_error
);

  localparam int unsigned W  = wordsize;
  localparam int unsigned AW = (ram_words > 1) ? $clog2(ram_words) : 1;

  decode_t      dec_c;
  mmio_off_e    off_c;
  logic [AW-1:0] ram_idx_c;
  logic          mmio_we_c;
  logic          ram_we_c;
  logic          reload_we_c;
  logic          expire_c;
  logic [W-1:0]  reload_val;
  logic [W-1:0]  count_val;
  logic [W-1:0]  mmio_rdata_c;

  logic [W-1:0]        ram_mem [ram_words];

  logic [W-1:0]        rdata_q, rdata_d;
  logic [GPIO_W-1:0]   gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0]   sync1_q, sync1_d;
  logic [GPIO_W-1:0]   sync2_q, sync2_d;
  logic [W-1:0]        cycles_q, cycles_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [W-1:0]        scratch_q, scratch_d;
  logic                timer_irq_q, timer_irq_d;

  // Address decode; MMIO window (top 8 words) wins over RAM.
  always_comb begin
    dec_c.mmio     = &cpu_addr[W-1:MMIO_OFF_W];
    dec_c.ram      = !dec_c.mmio && (cpu_addr < W'(ram_words));
    dec_c.unmapped = !dec_c.mmio && !dec_c.ram;
    off_c          = mmio_off_e'(cpu_addr[MMIO_OFF_W-1:0]);
    ram_idx_c      = cpu_addr[AW-1:0];
    mmio_we_c      = cpu_we && dec_c.mmio;
    ram_we_c       = cpu_we && dec_c.ram && reset;
    reload_we_c    = mmio_we_c && (off_c == MMIO_RELOAD);
  end

  reflet_mmio_timer #(
    .W (W)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .en           (ctrl_q[CTRL_TIMER_EN]),
    .reload_we    (reload_we_c),
    .reload_wdata (cpu_wdata),
    .reload       (reload_val),
    .count        (count_val),
    .expire_c     (expire_c)
  );

  // MMIO read mux over current register values.
  always_comb begin
    mmio_rdata_c = '0;
    case (off_c)
      MMIO_GPIO_OUT: mmio_rdata_c = W'(gpio_out_q);
      MMIO_GPIO_IN:  mmio_rdata_c = W'(sync2_q);
      MMIO_CYCLES:   mmio_rdata_c = cycles_q;
      MMIO_RELOAD:   mmio_rdata_c = reload_val;
      MMIO_COUNT:    mmio_rdata_c = count_val;
      MMIO_CTRL:     mmio_rdata_c = W'(ctrl_q);
      MMIO_STATUS:   mmio_rdata_c = W'(status_q);
      MMIO_SCRATCH:  mmio_rdata_c = scratch_q;
      default:       mmio_rdata_c = '0;
    endcase
  end

  // Next-state for read data, MMIO registers and sticky status (set beats W1C clear).
  always_comb begin
    logic [STATUS_W-1:0] clr;
    logic [STATUS_W-1:0] set;
    rdata_d     = '0;
    gpio_out_d  = gpio_out_q;
    sync1_d     = gpio_in;
    sync2_d     = sync1_q;
    cycles_d    = cycles_q + W'(1);
    ctrl_d      = ctrl_q;
    scratch_d   = scratch_q;
    clr         = '0;
    set         = '0;
    timer_irq_d = status_q[STATUS_EXPIRED] & ctrl_q[CTRL_IRQ_EN];

    if (dec_c.ram) begin
      rdata_d = ram_mem[ram_idx_c];
    end else if (dec_c.mmio) begin
      rdata_d = mmio_rdata_c;
    end

    if (mmio_we_c) begin
      case (off_c)
        MMIO_GPIO_OUT: gpio_out_d = cpu_wdata[GPIO_W-1:0];
        MMIO_CTRL:     ctrl_d     = cpu_wdata[CTRL_W-1:0];
        MMIO_STATUS:   clr        = cpu_wdata[STATUS_W-1:0];
        MMIO_SCRATCH:  scratch_d  = cpu_wdata;
        default:       ;
      endcase
    end

    set[STATUS_EXPIRED] = expire_c;
    set[STATUS_BUS_ERR] = dec_c.unmapped;
    status_d = (status_q & ~clr) | set;
  end

  // Register bank, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q     <= '0;
      gpio_out_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      cycles_q    <= '0;
      ctrl_q      <= '0;
      status_q    <= '0;
      scratch_q   <= '0;
      timer_irq_q <= 1'b0;
    end else begin
      rdata_q     <= rdata_d;
      gpio_out_q  <= gpio_out_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cycles_q    <= cycles_d;
      ctrl_q      <= ctrl_d;
      status_q    <= status_d;
      scratch_q   <= scratch_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      ram_mem[ram_idx_c] <= cpu_wdata;
    end
  end

  assign cpu_rdata = rdata_q;
  assign gpio_out  = gpio_out_q;
  assign timer_irq = timer_irq_q;
  assign bus_error = status_q[STATUS_BUS_ERR];

endmodule

// File: tb/tb_reflet_mem_responder.sv
// Bench for reflet_mem_responder: directed scenarios plus random traffic against a cycle-level model.
module tb_reflet_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic [15:0] cpu_rdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_irq;
  logic        bus_error;

  int n_checks = 0;
  int n_pass   = 0;

  reflet_mem_responder #(
    .wordsize  (16),
    .ram_words (256)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .bus_error (bus_error)
  );

  always #5 clk = ~clk;

  // Reference model state: what the memory map should hold after each edge.
  logic [15:0] m_ram [256];
  bit          m_ram_ok [256];
  logic [15:0] m_rdata;
  bit          m_rdata_ok;
  logic [7:0]  m_gpio_out, m_s1, m_s2;
  logic [15:0] m_cycles, m_reload, m_count, m_scratch;
  logic        m_timer_en, m_irq_en, m_expired, m_bus_err, m_irq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock edge of the memory map as seen by the CPU.
  task automatic model_step(input logic rst_n, input logic [15:0] a, input logic [15:0] wd,
                            input logic we, input logic [7:0] gin);
    bit   is_mmio, is_ram, is_unm, wr, expire_now;
    int   off;
    logic [15:0] rd;
    bit   rd_ok;
    logic new_irq;
    if (!rst_n) begin
      m_rdata = 0; m_rdata_ok = 1; m_gpio_out = 0; m_s1 = 0; m_s2 = 0;
      m_cycles = 0; m_reload = 0; m_count = 0; m_scratch = 0;
      m_timer_en = 0; m_irq_en = 0; m_expired = 0; m_bus_err = 0; m_irq = 0;
      return;
    end
    is_mmio = (a >= 16'hFFF8);
    is_ram  = !is_mmio && (a < 16'd256);
    is_unm  = !is_mmio && !is_ram;
    off     = int'(a % 16'd8);
    wr      = (we == 1'b1);
    rd      = 0;
    rd_ok   = 1;
    if (is_ram) begin
      rd = m_ram[a[7:0]]; rd_ok = m_ram_ok[a[7:0]];
    end else if (is_mmio) begin
      case (off)
        0: rd = {8'h00, m_gpio_out};
        1: rd = {8'h00, m_s2};
        2: rd = m_cycles;
        3: rd = m_reload;
        4: rd = m_count;
        5: rd = {14'd0, m_irq_en, m_timer_en};
        6: rd = {14'd0, m_bus_err, m_expired};
        default: rd = m_scratch;
      endcase
    end
    new_irq = m_expired && m_irq_en;
    expire_now = 0;
    if (wr && is_mmio && off == 3) begin
      m_reload = wd; m_count = wd;
    end else if (m_timer_en) begin
      if (m_count == 0) begin m_count = m_reload; expire_now = 1; end
      else m_count = m_count - 16'd1;
    end
    if (wr && is_mmio && off == 6) begin
      if (wd[0]) m_expired = 0;
      if (wd[1]) m_bus_err = 0;
    end
    if (expire_now) m_expired = 1;
    if (is_unm)     m_bus_err = 1;
    if (wr && is_mmio && off == 0) m_gpio_out = wd[7:0];
    if (wr && is_mmio && off == 5) begin m_timer_en = wd[0]; m_irq_en = wd[1]; end
    if (wr && is_mmio && off == 7) m_scratch = wd;
    if (wr && is_ram) begin m_ram[a[7:0]] = wd; m_ram_ok[a[7:0]] = 1; end
    m_s2 = m_s1;
    m_s1 = gin;
    m_cycles = m_cycles + 16'd1;
    m_irq = new_irq;
    m_rdata = rd;
    m_rdata_ok = rd_ok;
  endtask

  // Apply one bus cycle, advance the model and compare all outputs just after the edge.
  task automatic cycle(input logic [15:0] a, input logic [15:0] wd, input logic we);
    cpu_addr = a; cpu_wdata = wd; cpu_we = we;
    @(posedge clk);
    model_step(reset, a, wd, we, gpio_in);
    #1;
    if (m_rdata_ok) check("rdata", 64'(cpu_rdata), 64'(m_rdata));
    check("gpio_out", 64'(gpio_out), 64'(m_gpio_out));
    check("timer_irq", 64'(timer_irq), 64'(m_irq));
    check("bus_error", 64'(bus_error), 64'(m_bus_err));
  endtask

  initial begin
    int first_exp, first_irq;
    logic [15:0] c1, c2, a;
    logic [15:0] wd;
    for (int i = 0; i < 256; i++) begin m_ram[i] = 0; m_ram_ok[i] = 0; end
    reset = 1'b0; gpio_in = 8'h00;
    cpu_addr = 0; cpu_wdata = 0; cpu_we = 0;

    // Reset state
    cycle(16'h0000, 16'h0, 1'b0);
    cycle(16'hFFFF, 16'h0, 1'b0);
    check("rst_rdata", 64'(cpu_rdata), 64'h0);
    check("rst_gpio_out", 64'(gpio_out), 64'h0);
    check("rst_irq", 64'(timer_irq), 64'h0);
    check("rst_bus_error", 64'(bus_error), 64'h0);
    reset = 1'b1;

    // 1: RAM write then read with one-cycle latency
    cycle(16'd5, 16'h1234, 1'b1);
    cycle(16'd5, 16'h0, 1'b0);
    check("t1_ram_read", 64'(cpu_rdata), 64'h1234);

    // 2: read-first on simultaneous write
    cycle(16'd5, 16'hBEEF, 1'b1);
    check("t2_read_first", 64'(cpu_rdata), 64'h1234);
    cycle(16'd5, 16'h0, 1'b0);
    check("t2_new_data", 64'(cpu_rdata), 64'hBEEF);

    // 3: unmapped access, then W1C of bus_err
    cycle(16'h8000, 16'h0, 1'b0);
    check("t3_unmapped_rdata", 64'(cpu_rdata), 64'h0);
    check("t3_bus_error_set", 64'(bus_error), 64'h1);
    cycle(16'hFFFE, 16'h0002, 1'b1);
    check("t3_bus_error_clr", 64'(bus_error), 64'h0);

    // 4: reload timer with interrupt
    cycle(16'hFFFB, 16'd3, 1'b1);
    cycle(16'hFFFD, 16'd3, 1'b1);
    first_exp = 0; first_irq = 0;
    for (int i = 1; i <= 9; i++) begin
      cycle(16'hFFFE, 16'h0, 1'b0);
      if (first_exp == 0 && cpu_rdata[0]) first_exp = i;
      if (first_irq == 0 && timer_irq)    first_irq = i;
    end
    check("t4_first_expired", 64'(first_exp), 64'd5);
    check("t4_first_irq", 64'(first_irq), 64'd5);
    cycle(16'hFFFD, 16'd0, 1'b1);
    cycle(16'hFFFE, 16'd3, 1'b1);
    cycle(16'hFFFE, 16'd0, 1'b0);
    check("t4_w1c_status", 64'(cpu_rdata), 64'h0);

    // 5: GPIO and cycle counter
    cycle(16'hFFF8, 16'hFFA5, 1'b1);
    check("t5_gpio_out", 64'(gpio_out), 64'hA5);
    cycle(16'hFFF8, 16'h0, 1'b0);
    check("t5_gpio_readback", 64'(cpu_rdata), 64'h00A5);
    gpio_in = 8'h3C;
    cycle(16'hFFF9, 16'h0, 1'b0);
    cycle(16'hFFF9, 16'h0, 1'b0);
    cycle(16'hFFF9, 16'h0, 1'b0);
    check("t5_gpio_in", 64'(cpu_rdata), 64'h003C);
    cycle(16'hFFFA, 16'h0, 1'b0);
    c1 = cpu_rdata;
    for (int i = 0; i < 6; i++) cycle(16'd0, 16'h0, 1'b0);
    cycle(16'hFFFA, 16'h0, 1'b0);
    c2 = cpu_rdata;
    check("t5_cycles_delta", 64'(16'(c2 - c1)), 64'd7);

    // 6: reset in the middle of writes with the timer running
    gpio_in = 8'h00;
    cycle(16'hFFFB, 16'd5, 1'b1);
    cycle(16'hFFFD, 16'd3, 1'b1);
    cycle(16'hFFFF, 16'h0055, 1'b1);
    cycle(16'd1, 16'h0, 1'b0);
    cycle(16'd1, 16'h0, 1'b0);
    reset = 1'b0;
    cycle(16'hFFFF, 16'hAAAA, 1'b1);
    cycle(16'd5, 16'h7777, 1'b1);
    reset = 1'b1;
    foreach (c1[i]) begin end
    for (int o = 0; o < 8; o++) begin
      if (o == 2) continue;
      cycle(16'hFFF8 + 16'(o), 16'h0, 1'b0);
      check($sformatf("t6_reg%0d_zero", o), 64'(cpu_rdata), 64'h0);
    end
    cycle(16'd5, 16'h0, 1'b0);
    check("t6_ram_write_dropped", 64'(cpu_rdata), 64'hBEEF);

    // Random traffic: fill a small RAM window, then mixed accesses
    for (int i = 0; i < 16; i++) cycle(16'(i), 16'($urandom), 1'b1);
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5)      a = 16'($urandom_range(0, 15));
      else if (sel < 9) a = 16'hFFF8 + 16'($urandom_range(0, 7));
      else              a = 16'($urandom_range(256, 16'hFFF7));
      wd = 16'($urandom);
      if (a == 16'hFFFB) wd = 16'($urandom_range(0, 6));
      gpio_in = 8'($urandom);
      reset = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      cycle(a, wd, 1'($urandom_range(0, 1)));
    end
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
